// File: rtl/regfile_scoreboard.sv
// Two-read / one-write register file with optional zero register, write-to-read
// bypass and a per-register busy scoreboard for read-after-write hazard detection.
module regfile_scoreboard #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] rs,
    input  logic [ADDR_BITS-1:0] rt,
    output logic [WIDTH-1:0]     saidaA,
    output logic [WIDTH-1:0]     saidaB,
    input  logic                 wr,
    input  logic [ADDR_BITS-1:0] controle,
    input  logic [WIDTH-1:0]     entrada,
    input  logic                 mark,
    input  logic [ADDR_BITS-1:0] mark_addr,
    output logic                 busyA,
    output logic                 busyB,
    output logic                 hazard
);
    localparam int DEPTH  = 2 ** ADDR_BITS;
    localparam int NUM_RD = 2;

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_busy;

    logic [NUM_RD-1:0][ADDR_BITS-1:0] w_raddr;
    logic [NUM_RD-1:0][WIDTH-1:0]     w_rdata;
    logic [NUM_RD-1:0]                w_rbusy;

    logic w_wr_ok;
    assign w_wr_ok = wr && !((ZERO_REG != 0) && (controle == '0));

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int n = 0; n < DEPTH; n++) r_regs[n] <= '0;
            r_busy <= '0;
        end else begin
            if (w_wr_ok) r_regs[controle] <= entrada;
            // A mark in the same cycle as the clearing write wins: new producer pending.
            for (int n = 0; n < DEPTH; n++) begin
                if (mark && (mark_addr == ADDR_BITS'(n)))  r_busy[n] <= 1'b1;
                else if (wr && (controle == ADDR_BITS'(n))) r_busy[n] <= 1'b0;
            end
            if (ZERO_REG != 0) r_busy[0] <= 1'b0;
        end
    end

    assign w_raddr[0] = rs;
    assign w_raddr[1] = rt;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic w_zero, w_fwd;
        assign w_zero     = (ZERO_REG != 0) && (w_raddr[p] == '0);
        assign w_fwd      = (BYPASS != 0) && wr && (controle == w_raddr[p]);
        assign w_rdata[p] = w_zero ? '0 : (w_fwd ? entrada : r_regs[w_raddr[p]]);
        // A forwarded value satisfies the pending write, so no stall this cycle.
        assign w_rbusy[p] = !w_zero && !w_fwd && r_busy[w_raddr[p]];
    end

    assign saidaA = w_rdata[0];
    assign saidaB = w_rdata[1];
    assign busyA  = w_rbusy[0];
    assign busyB  = w_rbusy[1];
    assign hazard = busyA | busyB;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench: default config (ZERO_REG=1, BYPASS=1) and plain config (0/0) side by side
// on shared stimulus, checked against an array-based model of the register file.
module tb_regfile_scoreboard;
    logic        clock = 1'b0;
    logic        reset, wr, mark;
    logic [4:0]  rs, rt, controle, mark_addr;
    logic [31:0] entrada;
    logic [31:0] a1, b1, a0, b0;
    logic        ba1, bb1, hz1, ba0, bb0, hz0;

    int n_assert = 0;
    int n_fail   = 0;
    string step_tag = "init";

    // Model state; index c: 1 = zero reg + bypass, 0 = neither.
    logic [31:0] mem  [2][32];
    bit          busy [2][32];

    always #5 clock = ~clock;

    regfile_scoreboard #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .clock(clock), .reset(reset), .rs(rs), .rt(rt), .saidaA(a1), .saidaB(b1),
        .wr(wr), .controle(controle), .entrada(entrada), .mark(mark),
        .mark_addr(mark_addr), .busyA(ba1), .busyB(bb1), .hazard(hz1));

    regfile_scoreboard #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(0), .BYPASS(0)) dut0 (
        .clock(clock), .reset(reset), .rs(rs), .rt(rt), .saidaA(a0), .saidaB(b0),
        .wr(wr), .controle(controle), .entrada(entrada), .mark(mark),
        .mark_addr(mark_addr), .busyA(ba0), .busyB(bb0), .hazard(hz0));

    function automatic logic [31:0] exp_rd(int c, logic [4:0] a);
        if (c == 1 && a == 0) return 32'h0;
        if (c == 1 && wr && controle == a) return entrada;
        return mem[c][a];
    endfunction

    function automatic logic exp_bz(int c, logic [4:0] a);
        if (c == 1 && a == 0) return 1'b0;
        if (c == 1 && wr && controle == a) return 1'b0;
        return busy[c][a];
    endfunction

    task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %h expected %h", step_tag, name, obs, exp);
        end
    endtask

    task automatic check_all();
        logic ea, eb;
        chk("c1_saidaA", a1, exp_rd(1, rs));
        chk("c1_saidaB", b1, exp_rd(1, rt));
        ea = exp_bz(1, rs); eb = exp_bz(1, rt);
        chk("c1_busyA", {31'b0, ba1}, {31'b0, ea});
        chk("c1_busyB", {31'b0, bb1}, {31'b0, eb});
        chk("c1_hazard", {31'b0, hz1}, {31'b0, ea | eb});
        chk("c0_saidaA", a0, exp_rd(0, rs));
        chk("c0_saidaB", b0, exp_rd(0, rt));
        ea = exp_bz(0, rs); eb = exp_bz(0, rt);
        chk("c0_busyA", {31'b0, ba0}, {31'b0, ea});
        chk("c0_busyB", {31'b0, bb0}, {31'b0, eb});
        chk("c0_hazard", {31'b0, hz0}, {31'b0, ea | eb});
    endtask

    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            if (reset) begin
                for (int n = 0; n < 32; n++) begin mem[c][n] = '0; busy[c][n] = 0; end
            end else begin
                if (wr && !(c == 1 && controle == 0)) mem[c][controle] = entrada;
                if (wr) busy[c][controle] = 0;
                if (mark) busy[c][mark_addr] = 1;
                if (c == 1) busy[c][0] = 0;
            end
        end
    endtask

    // One cycle: present inputs, check settled outputs, clock, advance model.
    task automatic cyc(logic rst, logic [4:0] ra, logic [4:0] rb, logic w, logic [4:0] wa,
                       logic [31:0] wd, logic m, logic [4:0] ma);
        reset = rst; rs = ra; rt = rb; wr = w; controle = wa; entrada = wd;
        mark = m; mark_addr = ma;
        #2;
        check_all();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic idle(logic [4:0] ra, logic [4:0] rb);
        cyc(0, ra, rb, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int c = 0; c < 2; c++)
            for (int n = 0; n < 32; n++) begin mem[c][n] = 'x; busy[c][n] = 0; end
        reset = 1; wr = 0; mark = 0; rs = 0; rt = 0; controle = 0; entrada = 0; mark_addr = 0;
        @(posedge clock); model_edge(); #1;
        reset = 1; @(posedge clock); model_edge(); #1;

        step_tag = "reset_read";
        for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));

        step_tag = "write7";
        cyc(0, 7, 7, 1, 7, 32'hDEADBEEF, 0, 0);
        idle(7, 0);
        chk("write7_c1_after", a1, 32'hDEADBEEF);
        chk("write7_c0_after", a0, 32'hDEADBEEF);

        step_tag = "zero_reg";
        cyc(0, 0, 0, 1, 0, 32'h12345678, 1, 0);
        idle(0, 0);
        chk("zero_c1_data", a1, 32'h0);
        chk("zero_c1_busy", {31'b0, ba1}, 32'h0);
        chk("zero_c0_data", a0, 32'h12345678);
        cyc(0, 0, 0, 1, 0, 32'h0, 0, 0);

        step_tag = "lifecycle";
        cyc(0, 9, 9, 0, 0, 0, 1, 9);
        idle(9, 9);
        chk("life_c2_hazard", {31'b0, hz1}, 32'h1);
        idle(9, 9);
        chk("life_c3_hazard", {31'b0, hz0}, 32'h1);
        cyc(0, 9, 9, 1, 9, 32'hAA, 0, 0);
        idle(9, 9);
        chk("life_c5_busy1", {31'b0, ba1}, 32'h0);
        chk("life_c5_busy0", {31'b0, ba0}, 32'h0);

        step_tag = "mark_and_write";
        cyc(0, 3, 3, 0, 0, 0, 1, 3);
        cyc(0, 1, 2, 1, 3, 32'h55, 1, 3);
        idle(3, 3);
        chk("mw_data", a1, 32'h55);
        chk("mw_busy", {31'b0, ba1}, 32'h1);

        step_tag = "reset_mid";
        cyc(0, 4, 5, 1, 4, 32'h11, 0, 0);
        cyc(0, 4, 5, 1, 5, 32'h11, 1, 4);
        cyc(0, 4, 5, 0, 0, 0, 1, 5);
        idle(4, 5);
        cyc(1, 4, 5, 1, 4, 32'h99, 0, 0);
        idle(4, 5);
        chk("rst_data4", a0, 32'h0);
        chk("rst_hazard", {31'b0, hz0}, 32'h0);

        step_tag = "random";
        for (int k = 0; k < 400; k++) begin
            logic [4:0] ra, rb, wa, ma;
            ra = 5'($urandom_range(0, 7)); rb = 5'($urandom_range(0, 7));
            wa = 5'($urandom_range(0, 7)); ma = 5'($urandom_range(0, 7));
            cyc(($urandom_range(0, 59) == 0), ra, rb, 1'($urandom_range(0, 1)), wa,
                $urandom, ($urandom_range(0, 2) == 0), ma);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised multi-port register file for the MIPS datapath, sitting between decode and execute/writeback. It provides two combinational read ports and one synchronous write port. It adds an optional hardwired zero register and optional write-to-read bypass. A per-register busy scoreboard marks registers awaiting a pending write (e.g. loads), so decode can detect read-after-write hazards and stall.

## Interface

Parameters:
- WIDTH, 32, data width of each register.
- ADDR_BITS, 5, address width; depth is 2**ADDR_BITS.
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and is never busy.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.

Ports:
- clock, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high.
- rs, input, ADDR_BITS, read address for port A.
- rt, input, ADDR_BITS, read address for port B.
- saidaA, output, WIDTH, read data for port A.
- saidaB, output, WIDTH, read data for port B.
- wr, input, 1, write enable.
- controle, input, ADDR_BITS, write address.
- entrada, input, WIDTH, write data.
- mark, input, 1, set the busy bit of register mark_addr (pending producer issued).
- mark_addr, input, ADDR_BITS, register to mark busy.
- busyA, output, 1, register rs has a pending write.
- busyB, output, 1, register rt has a pending write.
- hazard, output, 1, equals busyA OR busyB; decode stall request.

## Operation

- State:
  - registrador[0..2**ADDR_BITS-1], each WIDTH bits.
  - busy[0..2**ADDR_BITS-1], one bit each.
- Reset (reset=1 at a rising edge):
  - Every register and every busy bit is cleared.
  - wr and mark are ignored in that cycle.
  - After reset: saidaA=saidaB=0, busyA=busyB=hazard=0.
- Write: when wr=1 and reset=0, registrador[controle] <= entrada at the edge. This is suppressed when ZERO_REG=1 and controle=0.
- Busy update, evaluated per register each edge with reset=0, in priority order:
  1. mark=1 and mark_addr=n sets busy[n]. This applies even if wr targets n in the same cycle: the new producer wins.
  2. Otherwise, wr=1 and controle=n clears busy[n].
  3. Otherwise, busy[n] holds.
  - With ZERO_REG=1, busy[0] stays 0 regardless of mark.
- Read port A (port B identical, using rt):
  - If ZERO_REG=1 and rs=0, saidaA=0.
  - Else if BYPASS=1, wr=1 and controle=rs, saidaA=entrada.
  - Else saidaA=registrador[rs].
- Busy output A (B identical):
  - busyA = busy[rs], forced 0 when ZERO_REG=1 and rs=0.
  - When BYPASS=1, it is also forced 0 when wr=1 and controle=rs, because the pending value is being forwarded this cycle.
  - When BYPASS=0, busyA reflects the stored bit only, so the stall lasts one cycle past the write.
- rs=rt is legal; both ports return identical data and busy.
- Writing a register that is not busy is legal and leaves busy unchanged at 0.

## Timing

- Reads, busyA/busyB and hazard are combinational from rs, rt and stored state. When BYPASS=1 they also depend combinationally on wr, controle and entrada.
- Write latency:
  - BYPASS=0: the written value is visible on a read port the cycle after the edge.
  - BYPASS=1: the value is visible in the same cycle it is presented on entrada.
- Busy latency: a mark at edge k makes busyA=1 (for rs=mark_addr) from cycle k+1 until the clearing write's cycle. The bypass rule above adjusts the clearing cycle.
- Reset mid-operation: any pending busy bits and stored data are lost at the reset edge. Any write in the reset cycle is dropped.
- No multi-cycle operations; throughput is one write, one mark and two reads per cycle.

## Test plan

- Reset, then read all addresses:
  - Required: saidaA=saidaB=0 and hazard=0 for every rs/rt.
- Write and read back (BYPASS=1, ZERO_REG=1):
  - Stimulus: wr=1, controle=7, entrada=0xDEADBEEF, rs=7 in the same cycle.
  - Required: saidaA=0xDEADBEEF that cycle and after.
  - Rerun with BYPASS=0: the old value 0 that cycle, 0xDEADBEEF the next.
- Zero register:
  - Stimulus: write 0x12345678 to address 0, and mark address 0.
  - Required: saidaA=0 and busyA=0 with rs=0.
  - Rerun with ZERO_REG=0: saidaA=0x12345678.
- Scoreboard lifecycle:
  - Stimulus: mark 9 at edge 1, hold rs=9, write 9 with 0xAA at cycle 4.
  - Required: hazard=1 during cycles 2-3.
  - Cycle 4: busyA=0 and saidaA=0xAA (BYPASS=1), or busyA=1 (BYPASS=0).
  - Cycle 5: busyA=0 in both cases.
- Simultaneous mark and write to the same register:
  - Stimulus: register 3 busy; in one cycle, wr to 3 with 0x55 and mark 3.
  - Required: registrador[3]=0x55 and busy[3] remains 1 afterward.
- Reset mid-operation:
  - Stimulus: registers 4 and 5 busy with data 0x11; assert reset together with wr to 4.
  - Required next cycle: all data 0, all busy 0, write dropped.
